// File: rtl/alu_issue.sv
// alu_issue: RV32I OP / OP-IMM decode-and-issue stage feeding the ALU.
// Decodes one instruction per input handshake into {A, B, ALU_Op, rd},
// buffers legal results in a small FIFO and flags illegal encodings.
module alu_issue #(
  parameter int DEPTH = 2  // FIFO entries, power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        illegal,
  output logic [31:0] illegal_instr
);

  // Pointer width relies on DEPTH being a power of two so pointers wrap
  // by plain binary overflow.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
  } entry_t;

  // Architectural state
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          illegal_q, illegal_d;
  logic [31:0]   illegal_instr_q, illegal_instr_d;

  // Decode results
  entry_t      dec_entry;
  logic        dec_legal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic accept, push, pop;
  entry_t head;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Decode the incoming word into ALU operands and a legality flag.
  always_comb begin
    dec_legal    = 1'b0;
    dec_entry    = '0;
    dec_entry.a  = in_rs1_val;
    dec_entry.rd = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec_entry.b  = in_rs2_val;
        dec_entry.op = {in_instr[30], funct3};
        // Only SUB and SRA use the alternate funct7.
        dec_legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b001: begin
            dec_entry.b  = {27'd0, in_instr[24:20]};
            dec_entry.op = 4'b0001;
            dec_legal    = (funct7 == F7_ZERO);
          end
          3'b101: begin
            dec_entry.b  = {27'd0, in_instr[24:20]};
            dec_entry.op = {in_instr[30], 3'b101};
            dec_legal    = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          end
          default: begin
            // Immediate bit 30 is data here, so op bit 3 is forced low
            // and SUB can never be produced from OP-IMM.
            dec_entry.b  = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_entry.op = {1'b0, funct3};
            dec_legal    = 1'b1;
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Handshakes: in_ready comes only from the registered count so a pop in
  // the same cycle cannot open a slot when full.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && dec_legal;
  assign pop       = out_valid && out_ready;

  // Next-state for FIFO occupancy, pointers and storage.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Illegal reporting: one-cycle pulse per accepted illegal word, last word held.
  always_comb begin
    illegal_d       = accept && !dec_legal;
    illegal_instr_d = illegal_instr_q;
    if (accept && !dec_legal) begin
      illegal_instr_d = in_instr;
    end
  end

  // State registers; reset discards every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      illegal_q       <= 1'b0;
      illegal_instr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      illegal_q       <= illegal_d;
      illegal_instr_q <= illegal_instr_d;
      mem_q           <= mem_d;
    end
  end

  // Head fields are zeroed while empty so no stale entry is ever visible.
  always_comb begin
    head = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign out_a         = head.a;
  assign out_b         = head.b;
  assign out_alu_op    = head.op;
  assign out_rd        = head.rd;
  assign illegal       = illegal_q;
  assign illegal_instr = illegal_instr_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed + randomized bench for alu_issue against a
// mnemonic-level reference model with a queue standing in for the FIFO.
module tb_alu_issue;

  localparam int DEPTH = 2;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs1_val, in_rs2_val;
  logic [31:0] out_a, out_b, illegal_instr;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        illegal;

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .illegal(illegal), .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
  } ent_t;

  ent_t        mq[$];
  logic        exp_ill;
  logic [31:0] exp_ill_instr;
  int          n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd);
    logic [4:0] rs1f, rs2f;
    rs1f = 5'($urandom);
    rs2f = 5'($urandom);
    return {f7, rs2f, rs1f, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd);
    logic [4:0] rs1f;
    rs1f = 5'($urandom);
    return {imm, rs1f, f3, rd, 7'h13};
  endfunction

  // Check outputs against the model, drive one cycle, advance the model.
  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                     input logic [31:0] r2, input bit ordy, input bit lg,
                     input logic [3:0] eop, input logic [31:0] eb);
    bit acc, pp;
    ent_t e;
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_a", out_a, mq[0].a);
      chk("out_b", out_b, mq[0].b);
      chk("out_alu_op", out_alu_op, mq[0].op);
      chk("out_rd", out_rd, mq[0].rd);
    end
    chk("illegal", illegal, exp_ill);
    chk("illegal_instr", illegal_instr, exp_ill_instr);
    in_valid   = v;
    in_instr   = ins;
    in_rs1_val = r1;
    in_rs2_val = r2;
    out_ready  = ordy;
    acc = v && (mq.size() < DEPTH);
    pp  = (mq.size() != 0) && ordy;
    if (pp) void'(mq.pop_front());
    exp_ill = acc && !lg;
    if (acc && !lg) exp_ill_instr = ins;
    if (acc && lg) begin
      e.a = r1; e.b = eb; e.op = eop; e.rd = ins[11:7];
      mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Build a random instruction from a mnemonic and its documented meaning.
  task automatic gen(input logic [31:0] r2, output logic [31:0] ins, output bit lg,
                     output logic [3:0] eop, output logic [31:0] eb);
    int kind, idx;
    logic [4:0]  rd, sh;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    rd   = 5'($urandom);
    sh   = 5'($urandom);
    imm  = 12'($urandom);
    kind = $urandom_range(0, 3);
    lg   = 1'b1;
    eop  = 4'd0;
    eb   = 32'd0;
    ins  = 32'd0;
    if (kind == 0 || kind == 3) begin
      idx = $urandom_range(0, 9);
      case (idx)
        0: begin ins = rtype(7'h00, 3'd0, rd); eop = 4'd0;  end // ADD
        1: begin ins = rtype(7'h20, 3'd0, rd); eop = 4'd8;  end // SUB
        2: begin ins = rtype(7'h00, 3'd1, rd); eop = 4'd1;  end // SLL
        3: begin ins = rtype(7'h00, 3'd2, rd); eop = 4'd2;  end // SLT
        4: begin ins = rtype(7'h00, 3'd3, rd); eop = 4'd3;  end // SLTU
        5: begin ins = rtype(7'h00, 3'd4, rd); eop = 4'd4;  end // XOR
        6: begin ins = rtype(7'h00, 3'd5, rd); eop = 4'd5;  end // SRL
        7: begin ins = rtype(7'h20, 3'd5, rd); eop = 4'd13; end // SRA
        8: begin ins = rtype(7'h00, 3'd6, rd); eop = 4'd6;  end // OR
        default: begin ins = rtype(7'h00, 3'd7, rd); eop = 4'd7; end // AND
      endcase
      eb = r2;
    end else if (kind == 1) begin
      idx = $urandom_range(0, 8);
      eb  = {{20{imm[11]}}, imm};
      case (idx)
        0: begin ins = itype(imm, 3'd0, rd); eop = 4'd0; end // ADDI
        1: begin ins = itype(imm, 3'd2, rd); eop = 4'd2; end // SLTI
        2: begin ins = itype(imm, 3'd3, rd); eop = 4'd3; end // SLTIU
        3: begin ins = itype(imm, 3'd4, rd); eop = 4'd4; end // XORI
        4: begin ins = itype(imm, 3'd6, rd); eop = 4'd6; end // ORI
        5: begin ins = itype(imm, 3'd7, rd); eop = 4'd7; end // ANDI
        6: begin ins = itype({7'h00, sh}, 3'd1, rd); eop = 4'd1;  eb = 32'(sh); end
        7: begin ins = itype({7'h00, sh}, 3'd5, rd); eop = 4'd5;  eb = 32'(sh); end
        default: begin ins = itype({7'h20, sh}, 3'd5, rd); eop = 4'd13; eb = 32'(sh); end
      endcase
    end else begin
      lg  = 1'b0;
      idx = $urandom_range(0, 4);
      case (idx)
        0: begin
          do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
          ins = rtype(f7, 3'($urandom), rd);
        end
        1: begin
          do f3 = 3'($urandom); while (f3 == 3'd0 || f3 == 3'd5);
          ins = rtype(7'h20, f3, rd);
        end
        2: begin
          do f7 = 7'($urandom); while (f7 == 7'h00);
          ins = itype({f7, sh}, 3'd1, rd);
        end
        3: begin
          do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
          ins = itype({f7, sh}, 3'd5, rd);
        end
        default: begin
          ins = $urandom;
          while (ins[6:0] == 7'h13 || ins[6:0] == 7'h33) ins[6:0] = 7'($urandom);
        end
      endcase
    end
  endtask

  logic [31:0] sub_w [3];

  initial begin
    logic [31:0] ins, r1, r2, eb;
    bit lg;
    logic [3:0] eop;
    n_chk = 0; n_pass = 0;
    exp_ill = 1'b0; exp_ill_instr = 32'd0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_rs1_val = '0; in_rs2_val = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_op", out_alu_op, 4'd0);
    chk("rst_out_rd", out_rd, 5'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_illegal_instr", illegal_instr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // add x3,x1,x2 ; srai x1,x1,3 ; addi x1,x0,-1
    cyc(1, 32'h002081B3, 32'd5, 32'd7, 1, 1, 4'b0000, 32'd7);
    cyc(1, 32'h4030D093, 32'h80000000, 32'd9, 1, 1, 4'b1101, 32'd3);
    cyc(1, 32'hFFF00093, 32'd11, 32'd9, 1, 1, 4'b0000, 32'hFFFFFFFF);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);

    // back-pressure: three SUBs with out_ready low, third waits for a pop
    sub_w[0] = 32'h40208233; sub_w[1] = 32'h402082B3; sub_w[2] = 32'h40208333;
    cyc(1, sub_w[0], 32'd100, 32'd1, 0, 1, 4'b1000, 32'd1);
    cyc(1, sub_w[1], 32'd200, 32'd2, 0, 1, 4'b1000, 32'd2);
    cyc(1, sub_w[2], 32'd300, 32'd3, 0, 1, 4'b1000, 32'd3);
    cyc(1, sub_w[2], 32'd300, 32'd3, 0, 1, 4'b1000, 32'd3);
    cyc(1, sub_w[2], 32'd300, 32'd3, 1, 1, 4'b1000, 32'd3);
    cyc(1, sub_w[2], 32'd300, 32'd3, 1, 1, 4'b1000, 32'd3);
    repeat (3) cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);

    // illegal: JAL, then OP funct3=100 with funct7=0100000, back to back
    cyc(1, 32'h0000006F, 32'd1, 32'd2, 1, 0, 4'd0, 32'd0);
    cyc(1, 32'h4020C1B3, 32'd1, 32'd2, 1, 0, 4'd0, 32'd0);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);

    // streaming: push and pop together with one entry resident, across wraps
    for (int i = 0; i < 8; i++) begin
      r1 = $urandom; r2 = $urandom;
      gen(r2, ins, lg, eop, eb);
      if (!lg) begin ins = rtype(7'h00, 3'd0, 5'(i)); lg = 1; eop = 4'd0; eb = r2; end
      cyc(1, ins, r1, r2, 1, lg, eop, eb);
    end
    repeat (2) cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);

    // reset mid-flight with two entries buffered
    cyc(1, 32'h002081B3, 32'd1, 32'd2, 0, 1, 4'd0, 32'd2);
    cyc(1, 32'h4030D093, 32'd3, 32'd4, 0, 1, 4'b1101, 32'd3);
    chk("pre_rst_full", in_ready, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_a", out_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    exp_ill = 1'b0; exp_ill_instr = 32'd0;
    repeat (2) cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);

    // randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      r1 = $urandom; r2 = $urandom;
      gen(r2, ins, lg, eop, eb);
      cyc($urandom_range(0, 3) != 0, ins, r1, r2, $urandom_range(0, 3) != 0, lg, eop, eb);
    end
    repeat (4) cyc(0, 32'd0, 32'd0, 32'd0, 1, 1, 4'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
